// File: rtl/image_pkg.sv
// Shared types and width helpers for the image reader/writer blocks.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  localparam int unsigned MAX_PIXEL_W = 64;
  localparam logic [MAX_PIXEL_W-1:0] PIXEL_ZERO = '0;

  // Index width for a dimension of n entries (n >= 2 in practice).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index width for a dimension carrying a one-pixel border on each side.
  function automatic int unsigned pad_idx_w(input int unsigned n);
    return idx_w(n + 2);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter over a W x H grid with clear and advance.
module raster_counter
  import image_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                adv_i,
  output logic [idx_w(H)-1:0] row_o,
  output logic [idx_w(W)-1:0] col_o,
  output logic                last_col_o,
  output logic                last_frame_o
);

  localparam int unsigned RW = idx_w(H);
  localparam int unsigned CW = idx_w(W);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign last_col_o   = (col_q == CW'(W - 1));
  assign last_frame_o = last_col_o && (row_q == RW'(H - 1));
  assign row_o        = row_q;
  assign col_o        = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_frame_o ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/image_raster_reader.sv
// Raster-order image memory reader producing a valid/ready pixel stream.
// Optional zero border around the frame: define IMAGE_READER_BORDER_PAD_EN.
module image_raster_reader
  import image_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [idx_w(IMG_HEIGHT)-1:0]    mem_row,
  output logic [idx_w(IMG_WIDTH)-1:0]     mem_col,
  input  logic [DATA_WIDTH-1:0]           mem_pixel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_pixel,
  output logic [pad_idx_w(IMG_HEIGHT)-1:0] out_row,
  output logic [pad_idx_w(IMG_WIDTH)-1:0]  out_col,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            out_eof
);

  localparam int unsigned ORW = pad_idx_w(IMG_HEIGHT);
  localparam int unsigned OCW = pad_idx_w(IMG_WIDTH);
`ifdef IMAGE_READER_BORDER_PAD_EN
  localparam int unsigned SW = IMG_WIDTH + 2;
  localparam int unsigned SH = IMG_HEIGHT + 2;
`else
  localparam int unsigned SW = IMG_WIDTH;
  localparam int unsigned SH = IMG_HEIGHT;
`endif
  localparam int unsigned SRW = idx_w(SH);
  localparam int unsigned SCW = idx_w(SW);

  state_t                  state_q;
  logic                    done_q, valid_q, sof_q, eol_q, eof_q;
  logic [DATA_WIDTH-1:0]   pixel_q;
  logic [ORW-1:0]          row_q;
  logic [OCW-1:0]          col_q;

  logic [SRW-1:0] r;
  logic [SCW-1:0] c;
  logic           last_col, last_frame, load, scan_clr, scan_adv, interior;

  assign load     = !valid_q || out_ready;
  assign scan_clr = abort || ((state_q == IDLE) && start);
  assign scan_adv = (state_q == SCAN) && load && !last_frame;

  raster_counter #(
    .W (SW),
    .H (SH)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (scan_clr),
    .adv_i        (scan_adv),
    .row_o        (r),
    .col_o        (c),
    .last_col_o   (last_col),
    .last_frame_o (last_frame)
  );

`ifdef IMAGE_READER_BORDER_PAD_EN
  logic [SRW-1:0]               r_nxt;
  logic [SCW-1:0]               c_nxt;
  logic                         nxt_interior;
  logic [idx_w(IMG_HEIGHT)-1:0] mem_row_q;
  logic [idx_w(IMG_WIDTH)-1:0]  mem_col_q;

  always_comb begin
    r_nxt = last_col ? r + SRW'(1) : r;
    c_nxt = last_col ? '0 : c + SCW'(1);
  end

  assign interior     = (r != '0) && (r <= SRW'(IMG_HEIGHT)) && (c != '0) && (c <= SCW'(IMG_WIDTH));
  assign nxt_interior = (r_nxt != '0) && (r_nxt <= SRW'(IMG_HEIGHT)) &&
                        (c_nxt != '0) && (c_nxt <= SCW'(IMG_WIDTH));

  // Address is set up one position ahead so the combinational read lines up
  // with the padded counter; border positions leave it untouched.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      mem_row_q <= '0;
      mem_col_q <= '0;
    end else if (scan_adv && nxt_interior) begin
      mem_row_q <= idx_w(IMG_HEIGHT)'(r_nxt - SRW'(1));
      mem_col_q <= idx_w(IMG_WIDTH)'(c_nxt - SCW'(1));
    end
  end

  assign mem_row = mem_row_q;
  assign mem_col = mem_col_q;
`else
  assign interior = 1'b1;
  assign mem_row  = r;
  assign mem_col  = c;
`endif

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      pixel_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= SCAN;
        end
        SCAN: begin
          if (load) begin
            valid_q <= 1'b1;
            pixel_q <= interior ? mem_pixel : PIXEL_ZERO[DATA_WIDTH-1:0];
            row_q   <= ORW'(r);
            col_q   <= OCW'(c);
            sof_q   <= (r == '0) && (c == '0);
            eol_q   <= last_col;
            eof_q   <= last_frame;
            if (last_frame) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_pixel = pixel_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;

endmodule

// File: doc/image_raster_reader.md
Name: image_raster_reader

Overview:
- Initiator for the image memory read port.
- Walks the frame in raster order, drives row/col addresses and samples the combinationally returned pixel.
- Emits pixels as a valid/ready stream with frame/line markers. This stream feeds the Sobel window/line-buffer stage.
- One frame per start request, with abort support.

Parameters:
- IMG_WIDTH, 8, pixels per row (>= 2)
- IMG_HEIGHT, 8, rows per frame (>= 2)
- DATA_WIDTH, 8, bits per pixel

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request one frame scan; sampled only in IDLE
- abort  in  1  synchronous cancel of current frame
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after last beat handshake
- mem_row  out  $clog2(IMG_HEIGHT)  memory row address
- mem_col  out  $clog2(IMG_WIDTH)  memory column address
- mem_pixel  in  DATA_WIDTH  combinational read data for (mem_row, mem_col)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_pixel  out  DATA_WIDTH  pixel data
- out_row  out  $clog2(IMG_HEIGHT+2)  stream row index of beat
- out_col  out  $clog2(IMG_WIDTH+2)  stream column index of beat
- out_sof  out  1  first beat of frame
- out_eol  out  1  last beat of a row
- out_eof  out  1  last beat of frame

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: busy, done, out_valid, out_pixel, out_row, out_col, out_sof, out_eol, out_eof, mem_row, mem_col.
  - Internal scan counters r = 0, c = 0.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - On start = 1: clear r/c to 0 and go to SCAN.
  - start in any other state is ignored.
- mem_row/mem_col are the registered scan counters driven directly. The memory answers in the same cycle.
- SCAN, on each cycle with load = (!out_valid || out_ready):
  - Register mem_pixel into out_pixel, (r, c) into out_row/out_col, and the flags; set out_valid = 1.
  - Advance c. When c wraps from IMG_WIDTH-1 to 0, increment r.
  - Flags: sof when r = 0 and c = 0; eol when c = W-1; eof when r = H-1 and c = W-1.
  - After the eof beat is loaded, go to DRAIN. Counters hold.
- DRAIN:
  - On out_valid && out_ready: clear out_valid, pulse done for one cycle, go to IDLE.
- Latency and throughput:
  - start sampled at edge N; first beat valid after edge N+1.
  - With out_ready held high: one beat per cycle, W*H consecutive beats.
  - done is high in the cycle immediately after the eof handshake; busy falls in the same cycle.
- Backpressure: while out_valid && !out_ready, every out_* signal and the counters are held stable. No beat is dropped or duplicated.
- abort = 1 in any state:
  - Next edge: state = IDLE, out_valid = 0, all flags 0, counters 0.
  - No done pulse.
  - abort has priority over start in the same cycle.
- rst mid-frame: identical to reset values; no done. rst has priority over abort.
- The stream index widths are sized for the padded frame. Without padding, the upper index values go unused.

Optional Feature:
- Macro: IMAGE_READER_BORDER_PAD_EN.
- Defined:
  - Stream frame is (IMG_HEIGHT+2) x (IMG_WIDTH+2) with a one-pixel zero border.
  - Border beats carry out_pixel = 0 and do not read memory; mem_row/mem_col hold their last value.
  - Interior stream position (R, C) reads memory (R-1, C-1).
  - Flags and out_row/out_col refer to padded coordinates; eof is at (H+1, W+1).
- Undefined: W*H beats, with stream coordinates equal to memory coordinates.

Decomposition:
- Shared package image_pkg holds:
  - state enum typedef (IDLE, SCAN, DRAIN);
  - localparam width helpers for row/col widths, padded and unpadded;
  - a zero-pixel constant.
- One natural sub-module: raster_counter.
  - Parameterized W/H row/col counter with clear, advance enable, and last_col/last_frame outputs.
  - Reused later by the Sobel output writer.

Test Plan:
- Default 8x8 memory holding pattern r*c, out_ready = 1, pulse start:
  - 64 consecutive beats with out_pixel = r*c (e.g. (7,7) = 49).
  - sof on beat 0 only; eol on beats 7, 15, ..., 63; eof on beat 63.
  - done high exactly one cycle after beat 63; busy low in that same cycle.
- Same frame, out_ready low for 4 cycles while beat (3,5) = 15 is presented:
  - out_pixel/row/col/flags stay constant.
  - Full stream equals the 64-value reference with no gaps or repeats.
  - Random ready toggling over the whole frame gives the same result.
- start re-pulsed at beat 10: ignored. abort at beat 20:
  - Next cycle out_valid = 0, busy = 0; done never pulses.
  - A following start restarts at (0,0), pixel 0, with sof.
- rst asserted mid-frame at beat 30:
  - All outputs 0 next cycle; no done.
  - A following start produces a complete correct frame.
- Non-square IMG_WIDTH = 5, IMG_HEIGHT = 3:
  - 15 beats; eol on beats 4, 9, 14.
  - Pixel at (2,4) = 8; eof on (2,4).
- With IMAGE_READER_BORDER_PAD_EN, 8x8:
  - 100 beats; row 0, row 9, col 0 and col 9 all 0.
  - Stream (3,4) = 2*3 = 6; eof at (9,9); done after beat 99.
